// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues PC-ordered reads to a 2-cycle-latency instruction memory
// and delivers {instruction, pc} downstream, absorbing stalls in a 2-entry skid FIFO.
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [15:0] flush_pc,
   output logic        mem_ren,
   output logic [15:0] mem_raddr,
   input  logic [15:0] mem_rdata,
   output logic [15:0] cur_instruction,
   output logic [15:0] cur_pc,
   output logic        cur_valid
);

   localparam int unsigned AW         = 16;
   localparam int unsigned DW         = 16;
   localparam int unsigned SKID_DEPTH = 2;
   localparam int unsigned CW         = 2;
   localparam int unsigned OW         = 3;

   typedef struct packed {
      logic [DW-1:0] instr;
      logic [AW-1:0] pc;
   } fetch_entry_t;

   logic [AW-1:0] pc_q, pc_d;
   logic          s1_v_q, s1_v_d;
   logic [AW-1:0] s1_pc_q, s1_pc_d;
   logic          s2_v_q, s2_v_d;
   logic [AW-1:0] s2_pc_q, s2_pc_d;
   fetch_entry_t  skid0_q, skid0_d;
   fetch_entry_t  skid1_q, skid1_d;
   logic [CW-1:0] skid_cnt_q, skid_cnt_d;

   logic          skid_empty;
   logic          consumed;
   logic          issue;
   logic [OW-1:0] occupancy;
   logic [OW-1:0] occ_net;
   logic          pop;
   logic          push;
   logic          push_ok;
   logic [CW-1:0] wr_idx;
   fetch_entry_t  incoming;

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         s1_v_q     <= 1'b0;
         s1_pc_q    <= '0;
         s2_v_q     <= 1'b0;
         s2_pc_q    <= '0;
         skid0_q    <= '0;
         skid1_q    <= '0;
         skid_cnt_q <= '0;
      end else begin
         pc_q       <= pc_d;
         s1_v_q     <= s1_v_d;
         s1_pc_q    <= s1_pc_d;
         s2_v_q     <= s2_v_d;
         s2_pc_q    <= s2_pc_d;
         skid0_q    <= skid0_d;
         skid1_q    <= skid1_d;
         skid_cnt_q <= skid_cnt_d;
      end
   end

   // Delivery and request decision; reset gates the outputs asynchronously
   always_comb begin
      skid_empty      = (skid_cnt_q == '0);
      cur_valid       = !reset && !flush && (!skid_empty || s2_v_q);
      cur_instruction = skid_empty ? mem_rdata : skid0_q.instr;
      cur_pc          = skid_empty ? s2_pc_q   : skid0_q.pc;
      consumed        = cur_valid && !stall;
      occupancy       = OW'(s1_v_q) + OW'(s2_v_q) + OW'(skid_cnt_q);
      occ_net         = occupancy - OW'(consumed);
      issue           = !reset && !stall && !flush && (occ_net <= OW'(1));
      mem_ren         = issue;
      mem_raddr       = pc_q;
   end

   // Next-state: PC advance, in-flight shift, skid pop/push
   always_comb begin
      pc_d       = pc_q;
      s1_v_d     = s1_v_q;
      s1_pc_d    = s1_pc_q;
      s2_v_d     = s2_v_q;
      s2_pc_d    = s2_pc_q;
      skid0_d    = skid0_q;
      skid1_d    = skid1_q;
      skid_cnt_d = skid_cnt_q;
      pop        = 1'b0;
      push       = 1'b0;
      push_ok    = 1'b0;
      wr_idx     = '0;
      incoming   = '{instr: mem_rdata, pc: s2_pc_q};

      if (flush) begin
         pc_d       = flush_pc;
         s1_v_d     = 1'b0;
         s2_v_d     = 1'b0;
         skid_cnt_d = '0;
      end else begin
         if (issue) begin
            pc_d = pc_q + AW'(1);
         end
         s1_v_d  = issue;
         s1_pc_d = pc_q;
         s2_v_d  = s1_v_q;
         s2_pc_d = s1_pc_q;

         // A stage-2 return bypasses the skid only when it is delivered directly
         pop     = consumed && !skid_empty;
         push    = s2_v_q && !(consumed && skid_empty);
         wr_idx  = skid_cnt_q - CW'(pop);
         push_ok = push && (wr_idx < CW'(SKID_DEPTH));

         if (pop) begin
            skid0_d = skid1_q;
         end
         if (push_ok) begin
            if (wr_idx == '0) begin
               skid0_d = incoming;
            end else begin
               skid1_d = incoming;
            end
         end
         skid_cnt_d = skid_cnt_q - CW'(pop) + CW'(push_ok);
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model, directed scenarios with literal
// expectations, then randomized stall/flush/reset traffic.
module tb_fetch_stage;

   localparam logic [15:0] RST_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic [15:0] flush_pc;
   logic        mem_ren;
   logic [15:0] mem_raddr;
   logic [15:0] mem_rdata;
   logic [15:0] cur_instruction;
   logic [15:0] cur_pc;
   logic        cur_valid;

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .flush           (flush),
      .flush_pc        (flush_pc),
      .mem_ren         (mem_ren),
      .mem_raddr       (mem_raddr),
      .mem_rdata       (mem_rdata),
      .cur_instruction (cur_instruction),
      .cur_pc          (cur_pc),
      .cur_valid       (cur_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pc;
      int unsigned due;
   } req_t;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned cyc      = 0;

   // Reference model state: outstanding reads (with arrival cycle) and buffered pcs
   req_t        req_q[$];
   logic [15:0] skid_q[$];
   logic [15:0] pc_m = RST_PC;

   // Memory environment: 2-cycle read pipeline driven from the observed request
   logic        req_v = 1'b0, ra1_v = 1'b0, ra2_v = 1'b0;
   logic [15:0] req_a = '0, ra1 = '0, ra2 = '0;

   logic        obs_valid, obs_ren;
   logic [15:0] obs_pc, obs_instr, obs_raddr;

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return a + 16'h0100;
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
   endtask

   // One clock cycle: drive inputs after the edge, compare at mid-cycle, advance the model
   task automatic step(input logic r, input logic s, input logic f, input logic [15:0] fp);
      logic        ready, e_valid, e_ren, consumed, had_skid;
      logic [15:0] e_pc;
      int          occ;
      req_t        rq;

      ra2_v = ra1_v; ra2 = ra1;
      ra1_v = req_v; ra1 = req_a;
      reset = r; stall = s; flush = f; flush_pc = fp;
      mem_rdata = ra2_v ? mem_f(ra2) : 16'($urandom);
      #4;

      ready    = !r && (req_q.size() > 0) && (req_q[0].due == cyc);
      had_skid = skid_q.size() > 0;
      e_valid  = !r && !f && (had_skid || ready);
      e_pc     = had_skid ? skid_q[0] : (ready ? req_q[0].pc : 16'h0000);
      consumed = e_valid && !s;
      occ      = req_q.size() + skid_q.size() - (consumed ? 1 : 0);
      e_ren    = !r && !s && !f && (occ <= 1);

      chk("mem_ren", 16'(mem_ren), 16'(e_ren));
      if (e_ren) chk("mem_raddr", mem_raddr, pc_m);
      chk("cur_valid", 16'(cur_valid), 16'(e_valid));
      if (e_valid) begin
         chk("cur_pc", cur_pc, e_pc);
         chk("cur_instruction", cur_instruction, mem_f(e_pc));
      end

      obs_valid = cur_valid; obs_pc = cur_pc; obs_instr = cur_instruction;
      obs_ren = mem_ren; obs_raddr = mem_raddr;
      req_v = mem_ren; req_a = mem_raddr;

      if (r || f) begin
         req_q.delete();
         skid_q.delete();
         pc_m = r ? RST_PC : fp;
      end else begin
         if (consumed && had_skid) void'(skid_q.pop_front());
         if (ready) begin
            rq = req_q.pop_front();
            if (!(consumed && !had_skid)) skid_q.push_back(rq.pc);
         end
         if (e_ren) begin
            req_q.push_back('{pc: pc_m, due: cyc + 2});
            pc_m = pc_m + 16'h0001;
         end
      end

      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic pin(input string name, input logic v, input logic [15:0] pc);
      chk({name, "_valid"}, 16'(obs_valid), 16'(v));
      if (v) begin
         chk({name, "_pc"}, obs_pc, pc);
         chk({name, "_instr"}, obs_instr, pc + 16'h0100);
      end
   endtask

   initial begin
      logic r, s, f;
      logic [15:0] fp;
      reset = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0; mem_rdata = '0;
      #1 reset = 1'b1;
      @(posedge clk); #1;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("reset_ren", 16'(obs_ren), 16'h0000);

      // Reset release, free-running stream
      step(0, 0, 0, 0); chk("c1_ren", 16'(obs_ren), 16'h0001); chk("c1_addr", obs_raddr, 16'h0000);
      step(0, 0, 0, 0); pin("c2", 0, 0);
      step(0, 0, 0, 0); pin("c3", 1, 16'h0000);
      step(0, 0, 0, 0); pin("c4", 1, 16'h0001);
      step(0, 0, 0, 0); pin("c5", 1, 16'h0002);
      step(0, 0, 0, 0); pin("c6", 1, 16'h0003);
      step(0, 0, 0, 0); pin("c7", 1, 16'h0004);

      // Four-cycle stall: skid fills, no requests, no loss
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0);
         pin("stall4", 1, 16'h0005);
         chk("stall4_ren", 16'(obs_ren), 16'h0000);
      end
      step(0, 0, 0, 0); pin("rel0", 1, 16'h0005); chk("rel0_addr", obs_raddr, 16'h0007);
      step(0, 0, 0, 0); pin("rel1", 1, 16'h0006);
      step(0, 0, 0, 0); pin("rel2", 1, 16'h0007);
      step(0, 0, 0, 0); pin("rel3", 1, 16'h0008);

      // Single-cycle stall
      step(0, 1, 0, 0); pin("st1", 1, 16'h0009);
      step(0, 0, 0, 0); pin("st1_a", 1, 16'h0009);
      step(0, 0, 0, 0); pin("st1_b", 1, 16'h000A);
      step(0, 0, 0, 0); pin("st1_c", 1, 16'h000B);
      step(0, 0, 0, 0); pin("st1_d", 1, 16'h000C);

      // Flush with two reads in flight
      step(0, 0, 1, 16'h0040); pin("fl0", 0, 0); chk("fl0_ren", 16'(obs_ren), 16'h0000);
      step(0, 0, 0, 0); pin("fl1", 0, 0); chk("fl1_addr", obs_raddr, 16'h0040);
      step(0, 0, 0, 0); pin("fl2", 0, 0);
      step(0, 0, 0, 0); pin("fl3", 1, 16'h0040);
      step(0, 0, 0, 0); pin("fl4", 1, 16'h0041);

      // Flush together with stall: flush wins
      step(0, 1, 1, 16'h0010); pin("fs0", 0, 0);
      step(0, 0, 0, 0); pin("fs1", 0, 0);
      chk("fs1_ren", 16'(obs_ren), 16'h0001); chk("fs1_addr", obs_raddr, 16'h0010);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0); pin("fs3", 1, 16'h0010);

      // PC wrap, then reset mid-stream
      step(0, 0, 1, 16'hFFFE);
      step(0, 0, 0, 0); chk("wr_a0", obs_raddr, 16'hFFFE);
      step(0, 0, 0, 0); chk("wr_a1", obs_raddr, 16'hFFFF);
      step(0, 0, 0, 0); chk("wr_a2", obs_raddr, 16'h0000); pin("wr_d0", 1, 16'hFFFE);
      step(0, 0, 0, 0); pin("wr_d1", 1, 16'hFFFF);
      step(0, 0, 0, 0); pin("wr_d2", 1, 16'h0000);
      step(1, 0, 0, 0); pin("rst_mid", 0, 0); chk("rst_mid_ren", 16'(obs_ren), 16'h0000);
      step(0, 0, 0, 0); pin("rst_r0", 0, 0); chk("rst_r0_addr", obs_raddr, RST_PC);
      step(0, 0, 0, 0); pin("rst_r1", 0, 0);
      step(0, 0, 0, 0); pin("rst_r2", 1, RST_PC);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         r  = ($urandom_range(0, 199) == 0);
         s  = ($urandom_range(0, 99) < 35);
         f  = ($urandom_range(0, 99) < 3);
         fp = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                          : 16'($urandom);
         step(r, s, f, fp);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  downstream cannot accept an instruction this cycle.
REQ-005 SHALL have port flush  input  1  redirect; squash all fetched or in-flight work.
REQ-006 SHALL have port flush_pc  input  16  redirect target, sampled when flush=1.
REQ-007 SHALL have port mem_ren  output  1  instruction-memory read request this cycle.
REQ-008 SHALL have port mem_raddr  output  16  word address of the request, equal to the current PC.
REQ-009 SHALL have port mem_rdata  input  16  read data, valid exactly 2 cycles after the accepted mem_ren.
REQ-010 SHALL have port cur_instruction  output  16  instruction delivered downstream.
REQ-011 SHALL have port cur_pc  output  16  address of cur_instruction.
REQ-012 SHALL have port cur_valid  output  1  cur_instruction/cur_pc are meaningful.

Function
REQ-013 SHALL track requests in a 2-stage in-flight pipeline: valid bit plus PC per stage; stage 2 coincides with mem_rdata arrival.
REQ-014 SHALL hold a 2-entry in-order skid FIFO of {instruction, pc} for returns arriving while stall=1.
REQ-015 SHALL drive cur_* from the skid FIFO head when it is non-empty, else from the stage-2 return (mem_rdata, stage-2 PC).
REQ-016 SHALL assert cur_valid when (skid non-empty or stage-2 valid) and flush=0.
REQ-017 SHALL treat an instruction as consumed iff cur_valid=1 and stall=0; a consumed skid entry is popped.
REQ-018 SHALL push an unconsumed stage-2 return into the skid FIFO, including the case where the skid head is consumed in the same cycle.
REQ-019 SHALL define occupancy = in-flight valid count + skid count; mem_ren=1 iff stall=0, flush=0, and occupancy minus (1 if consumed this cycle) is at most 1.
REQ-020 SHALL increment the PC by 1 (16-bit, wrapping 16'hFFFF -> 16'h0000) on each cycle with mem_ren=1; the PC holds otherwise.
REQ-021 SHALL, on flush=1, load the PC with flush_pc, clear all in-flight valids, empty the skid FIFO, and deassert mem_ren and cur_valid that cycle; flush has priority over stall.
REQ-022 SHALL issue the first request after a flush at flush_pc in the cycle following the flush.
REQ-023 SHALL, with stall=0 continuously, sustain one instruction per cycle after an initial 2-cycle latency.
REQ-024 SHALL never overflow the skid FIFO (guaranteed by REQ-019) and never deliver an instruction twice or out of address order between flushes.

Reset
REQ-025 SHALL, while reset=1, set PC=RESET_PC, clear in-flight valids, empty the skid FIFO, and force mem_ren=0 and cur_valid=0 asynchronously.
REQ-026 SHALL assert mem_ren with mem_raddr=RESET_PC in the first cycle after reset deasserts, if stall=0.
REQ-027 SHALL, on reset asserted mid-operation, discard all in-flight and buffered instructions; no stale mem_rdata SHALL appear on cur_*.

Verification
REQ-028 SHALL cover: reset release, stall=0, memory returns mem[a]=a+16'h100 -> cur_valid first high in cycle 3 with cur_pc=0 and cur_instruction=16'h0100, then pc 1,2,3 on consecutive cycles.
REQ-029 SHALL cover: stall=1 for 4 cycles mid-stream -> mem_ren low after the stall begins, skid holds 2 entries, no loss; on release cur_pc continues contiguously with no gap or duplicate.
REQ-030 SHALL cover: stall=1 for exactly 1 cycle -> cur_pc repeats its value only across the stalled cycle, then continues at +1 per cycle, with skid count at most 2.
REQ-031 SHALL cover: flush=1 with flush_pc=16'h0040 while 2 requests are in flight -> cur_valid=0 for 2 cycles, then cur_pc=16'h0040, 16'h0041.
REQ-032 SHALL cover: flush and stall asserted together with flush_pc=16'h0010 -> flush wins; PC=16'h0010 and skid empty next cycle.
REQ-033 SHALL cover: PC at 16'hFFFF -> the next request address is 16'h0000, and reset asserted mid-stream clears cur_valid immediately.
